// File: rtl/lz77_enc_ctrl.sv
// LZ77 encoder frame controller: streams one frame of characters from ROM into the
// encoder and buffers its tokens in a small FIFO. Optional statistics under LZ77_CTRL_STATS_EN.
module lz77_enc_ctrl #(
  parameter int NCHAR      = 8192,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rom_rd,
  output logic [12:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        enc_rst,
  output logic [7:0]  enc_chardata,
  input  logic        enc_valid,
  input  logic        enc_finish,
  input  logic [4:0]  enc_offset,
  input  logic [4:0]  enc_match_len,
  input  logic [7:0]  enc_char_nxt,
  output logic        tok_valid,
  input  logic        tok_ready,
  output logic [4:0]  tok_offset,
  output logic [4:0]  tok_len,
  output logic [7:0]  tok_char,
  output logic        tok_last,
  output logic        busy,
  output logic        done,
  output logic        overflow
`ifdef LZ77_CTRL_STATS_EN
  ,
  output logic [13:0] stat_tokens,
  output logic [13:0] stat_literals
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [12:0]   LAST_ADDR = 13'(NCHAR - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    END_CHAR  = 8'h24;

  typedef enum logic [2:0] {IDLE, LOAD, ENCODE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [4:0] offset;
    logic [4:0] len;
    logic [7:0] chr;
    logic       last;
  } tok_t;

  state_t        state_q, state_d;
  logic [12:0]   addr_q, addr_d;
  logic          enc_rst_q, enc_rst_d;
  logic          overflow_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  tok_t          mem_q [FIFO_DEPTH];
  tok_t          push_tok, head;

  logic accept_start, push_req, pop, full, push_ok, drop;

  assign accept_start = (state_q == IDLE) && start;
  assign push_req     = (state_q == ENCODE) && enc_valid;
  assign tok_valid    = (count_q != '0);
  assign pop          = tok_valid && tok_ready;
  assign full         = (count_q == FULL_CNT);
  assign push_ok      = push_req && (!full || pop);
  assign drop         = push_req && full && !pop;

  assign push_tok = '{offset: enc_offset, len: enc_match_len, chr: enc_char_nxt,
                      last: (enc_char_nxt == END_CHAR)};

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ENCODE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 13'd1;
        end
      end
      ENCODE: if (enc_finish) state_d = DRAIN;
      DRAIN:  if (count_q == '0) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Released after the first LOAD cycle so the first encoder edge sees byte 0.
    enc_rst_d = !((state_q == LOAD) || (state_q == ENCODE && state_d == ENCODE));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      enc_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      enc_rst_q <= enc_rst_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (accept_start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // NOTE: token storage is not reset; the outputs are gated by tok_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_tok;
  end

  assign head         = mem_q[rd_ptr_q];
  assign tok_offset   = tok_valid ? head.offset : '0;
  assign tok_len      = tok_valid ? head.len    : '0;
  assign tok_char     = tok_valid ? head.chr    : '0;
  assign tok_last     = tok_valid ? head.last   : 1'b0;

  assign rom_rd       = (state_q == LOAD);
  assign rom_addr     = addr_q;
  assign enc_rst      = enc_rst_q;
  assign enc_chardata = rom_data;
  assign busy         = (state_q == LOAD) || (state_q == ENCODE) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign overflow     = overflow_q;

`ifdef LZ77_CTRL_STATS_EN
  logic [13:0] stat_tok_q, stat_lit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_tok_q <= '0;
      stat_lit_q <= '0;
    end else if (accept_start) begin
      stat_tok_q <= '0;
      stat_lit_q <= '0;
    end else if (push_ok) begin
      if (stat_tok_q != '1) stat_tok_q <= stat_tok_q + 14'd1;
      if (enc_match_len == '0 && stat_lit_q != '1) stat_lit_q <= stat_lit_q + 14'd1;
    end
  end

  assign stat_tokens   = stat_tok_q;
  assign stat_literals = stat_lit_q;
`endif

endmodule

// File: tb/tb_lz77_enc_ctrl.sv
// Self-checking bench for lz77_enc_ctrl: ROM model, hand-driven encoder tokens,
// table-driven token checks plus directed overflow, full-FIFO and reset sequences.
module tb_lz77_enc_ctrl;
  localparam int NCHAR      = 8192;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rom_rd;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data = 8'hAA;
  logic        enc_rst;
  logic [7:0]  enc_chardata;
  logic        enc_valid = 1'b0, enc_finish = 1'b0;
  logic [4:0]  enc_offset = '0, enc_match_len = '0;
  logic [7:0]  enc_char_nxt = '0;
  logic        tok_valid, tok_ready = 1'b1;
  logic [4:0]  tok_offset, tok_len;
  logic [7:0]  tok_char;
  logic        tok_last;
  logic        busy, done, overflow;
`ifdef LZ77_CTRL_STATS_EN
  logic [13:0] stat_tokens, stat_literals;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lz77_enc_ctrl #(.NCHAR(NCHAR), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .enc_rst(enc_rst), .enc_chardata(enc_chardata),
    .enc_valid(enc_valid), .enc_finish(enc_finish),
    .enc_offset(enc_offset), .enc_match_len(enc_match_len), .enc_char_nxt(enc_char_nxt),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_offset(tok_offset), .tok_len(tok_len), .tok_char(tok_char), .tok_last(tok_last),
    .busy(busy), .done(done), .overflow(overflow)
`ifdef LZ77_CTRL_STATS_EN
    , .stat_tokens(stat_tokens), .stat_literals(stat_literals)
`endif
  );

  // ROM: address k holds k[3:0], one-cycle read latency.
  always @(posedge clk) if (rom_rd) rom_data <= {4'h0, rom_addr[3:0]};

  // Load monitor, sampled mid-cycle so values match what the next rising edge sees.
  logic mon_en = 1'b0;
  logic load_seen = 1'b0;
  int   exp_addr = 0, addr_err = 0, gap_err = 0, enc_edge = 0, char_err = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rom_rd === 1'b1) begin
        load_seen <= 1'b1;
        if (rom_addr !== 13'(exp_addr)) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 1;
      end else if (load_seen && exp_addr < NCHAR) begin
        gap_err <= gap_err + 1;
      end
      if (enc_rst === 1'b0 && enc_edge < NCHAR) begin
        if (enc_chardata !== 8'(enc_edge % 16)) char_err <= char_err + 1;
        enc_edge <= enc_edge + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_load();
    int n = 0;
    while (rom_rd === 1'b1 && n < NCHAR + 100) begin
      tick();
      n++;
    end
    check("load_complete", {rom_rd, busy}, 2'b01);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("done_seen", done, 1'b1);
    tick();
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic drive_tok(input logic [4:0] off, input logic [4:0] len, input logic [7:0] chr);
    enc_valid     = 1'b1;
    enc_offset    = off;
    enc_match_len = len;
    enc_char_nxt  = chr;
  endtask

  typedef struct {
    logic [4:0] off;
    logic [4:0] len;
    logic [7:0] chr;
    logic [4:0] exp_off;
    logic [4:0] exp_len;
    logic [7:0] exp_chr;
    logic       exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5'd0,  5'd0,  8'h00, 5'd0,  5'd0,  8'h00, 1'b0};
    vecs[1] = '{5'd1,  5'd3,  8'h41, 5'd1,  5'd3,  8'h41, 1'b0};
    vecs[2] = '{5'd31, 5'd31, 8'hFF, 5'd31, 5'd31, 8'hFF, 1'b0};
    vecs[3] = '{5'd5,  5'd0,  8'h23, 5'd5,  5'd0,  8'h23, 1'b0};
    vecs[4] = '{5'd3,  5'd1,  8'h24, 5'd3,  5'd1,  8'h24, 1'b1};
    vecs[5] = '{5'd2,  5'd4,  8'h25, 5'd2,  5'd4,  8'h25, 1'b0};

    // Reset state
    tick(); tick();
    check("rst_rom_rd",    rom_rd,    1'b0);
    check("rst_rom_addr",  rom_addr,  13'd0);
    check("rst_enc_rst",   enc_rst,   1'b1);
    check("rst_tok_valid", tok_valid, 1'b0);
    check("rst_tok_fields", {tok_offset, tok_len, tok_char, tok_last}, 19'd0);
    check("rst_status",    {busy, done, overflow}, 3'b000);
    reset = 1'b0;
    tick();
    check("idle_enc_rst", {enc_rst, rom_rd, busy}, 3'b100);

    // Frame 1: monitored load, table-driven tokens, finish, done pulse
    mon_en = 1'b1;
    pulse_start();
    check("load_first", {rom_rd, rom_addr, busy, enc_rst}, {1'b1, 13'd0, 1'b1, 1'b1});
    tick();
    check("load_second", {rom_addr, enc_rst}, {13'd1, 1'b0});
    wait_load();
    pulse_start();
    check("start_in_encode_ignored", {rom_rd, busy}, 2'b01);
    for (int i = 0; i < 6; i++) begin
      drive_tok(vecs[i].off, vecs[i].len, vecs[i].chr);
      tick();
      enc_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), tok_valid, 1'b1);
      check($sformatf("vec%0d_fields", i), {tok_offset, tok_len, tok_char, tok_last},
            {vecs[i].exp_off, vecs[i].exp_len, vecs[i].exp_chr, vecs[i].exp_last});
      tick();
      check($sformatf("vec%0d_popped", i), tok_valid, 1'b0);
    end
    check("load_addr_sequence", addr_err, 0);
    check("load_addr_count",    exp_addr, NCHAR);
    check("load_no_gaps",       gap_err,  0);
    check("enc_byte_alignment", char_err, 0);
    check("enc_edge_count",     enc_edge, NCHAR);
    mon_en = 1'b0;

    drive_tok(5'd9, 5'd1, 8'h24);
    enc_finish = 1'b1;
    tick();
    enc_valid = 1'b0;
    enc_finish = 1'b0;
    check("finish_token_pushed", {tok_valid, tok_last, tok_char}, {1'b1, 1'b1, 8'h24});
    check("drain_enc_rst", {enc_rst, busy, done}, 3'b110);
    tick();
    check("drain_empty", {tok_valid, done}, 2'b00);
    tick();
    check("done_after_empty", {done, busy}, 2'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", {done, busy, rom_rd}, 3'b000);
`ifdef LZ77_CTRL_STATS_EN
    check("stat_tokens",   stat_tokens,   14'd7);
    check("stat_literals", stat_literals, 14'd2);
`endif

    // Frame 2: stalled downstream, overflow on the fifth token
    tok_ready = 1'b0;
    pulse_start();
`ifdef LZ77_CTRL_STATS_EN
    check("stat_cleared_on_start", {stat_tokens, stat_literals}, 28'd0);
`endif
    wait_load();
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
      drive_tok(5'(i), 5'd0, 8'(8'h30 + i));
      tick();
      if (i == FIFO_DEPTH) check("ovf_at_full", overflow, 1'b0);
    end
    enc_valid = 1'b0;
    check("ovf_on_drop", overflow, 1'b1);
    tok_ready = 1'b1;
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      check($sformatf("ovf_head%0d", i), {tok_valid, tok_offset}, {1'b1, 5'(i)});
      tick();
    end
    check("ovf_dropped_token_absent", tok_valid, 1'b0);
    enc_finish = 1'b1;
    tick();
    enc_finish = 1'b0;
    wait_done();
    check("ovf_sticky_idle", overflow, 1'b1);

    // Start clears overflow; reset mid-load at address 100
    pulse_start();
    check("start_clears_ovf", {overflow, rom_rd}, 2'b01);
    begin
      int n = 0;
      while (rom_addr !== 13'd100 && n < 200) begin
        tick();
        n++;
      end
    end
    check("reached_addr_100", rom_addr, 13'd100);
    reset = 1'b1;
    #1;
    check("midload_rst_outputs", {rom_rd, rom_addr, enc_rst, busy, done, overflow, tok_valid},
          {1'b0, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    tick();
    reset = 1'b0;
    tick();
    check("midload_rst_idle", {rom_rd, busy, done}, 3'b000);

    // Frame 3: reload from 0, full FIFO with simultaneous push and pop
    pulse_start();
    check("reload_from_zero", {rom_rd, rom_addr}, {1'b1, 13'd0});
    wait_load();
    tok_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      drive_tok(5'(10 + i), 5'(i), 8'(8'h50 + i));
      tick();
    end
    check("full_head", {tok_valid, tok_offset, overflow}, {1'b1, 5'd10, 1'b0});
    drive_tok(5'd14, 5'd7, 8'h60);
    tok_ready = 1'b1;
    tick();
    enc_valid = 1'b0;
    check("pushpop_full_no_ovf", {overflow, tok_valid, tok_offset}, {1'b0, 1'b1, 5'd11});
    for (int j = 11; j <= 14; j++) begin
      check($sformatf("pushpop_order%0d", j), {tok_valid, tok_offset}, {1'b1, 5'(j)});
      tick();
    end
    check("pushpop_drained", {tok_valid, overflow}, 2'b00);

    // Reset during ENCODE with queued tokens: no done pulse, queue discarded
    tok_ready = 1'b0;
    drive_tok(5'd1, 5'd1, 8'h61);
    tick();
    drive_tok(5'd2, 5'd2, 8'h62);
    tick();
    enc_valid = 1'b0;
    check("queued_before_rst", tok_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("encode_rst_discard", {tok_valid, tok_offset, busy, done, enc_rst}, {1'b0, 5'd0, 1'b0, 1'b0, 1'b1});
    tick();
    reset = 1'b0;
    begin
      int done_cnt = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (done === 1'b1) done_cnt++;
      end
      check("no_done_after_abort", done_cnt, 0);
    end
    check("idle_after_abort", {tok_valid, busy}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lz77_enc_ctrl.md
LZ77_ENC_CTRL -- requirements
Module: lz77_enc_ctrl

Interface
REQ-001 Parameter NCHAR, 8192, number of input characters per frame; the encoder's frame size.
REQ-002 Parameter FIFO_DEPTH, 4, token FIFO entries; power of two, >=2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a frame; accepted only in IDLE.
REQ-006 rom_rd  output  1  character ROM read strobe.
REQ-007 rom_addr  output  13  character ROM address; data returns one cycle later.
REQ-008 rom_data  input  8  ROM read data.
REQ-009 enc_rst  output  1  registered reset to encoder, active-high.
REQ-010 enc_chardata  output  8  equals rom_data, combinational passthrough.
REQ-011 enc_valid, enc_finish  input  1 each  encoder token strobe and end flag.
REQ-012 enc_offset, enc_match_len  input  5 each; enc_char_nxt  input  8  encoder token fields.
REQ-013 tok_valid  output  1; tok_ready  input  1  downstream handshake; transfer when both high.
REQ-014 tok_offset  output  5; tok_len  output  5; tok_char  output  8; tok_last  output  1  FIFO head token.
REQ-015 busy, done, overflow  output  1 each  status.

Function
REQ-016 FSM states IDLE, LOAD, ENCODE, DRAIN, DONE; encoding is implementation choice.
REQ-017 IDLE: enc_rst=1, rom_rd=0, busy=0; start -> LOAD.
REQ-018 LOAD: rom_rd=1, rom_addr steps 0..NCHAR-1, one per cycle, no gaps.
REQ-019 enc_rst goes 0 such that the first enc_clk edge with enc_rst=0 samples byte at address 0 on enc_chardata; bytes k arrive on consecutive edges.
REQ-020 After address NCHAR-1 is issued: rom_rd=0, LOAD -> ENCODE.
REQ-021 ENCODE: each enc_valid=1 cycle pushes {offset,match_len,char_nxt,last} into FIFO; last=1 iff enc_char_nxt==8'h24.
REQ-022 ENCODE -> DRAIN on first enc_finish=1 sample; tokens with enc_valid in that cycle still pushed.
REQ-023 DRAIN: enc_rst=1; -> DONE when FIFO empty.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 busy=1 in LOAD, ENCODE, DRAIN.
REQ-026 tok_valid = FIFO non-empty; tok_* show head entry; pop on tok_valid & tok_ready.
REQ-027 Push and pop same cycle when full: both occur, count unchanged, no overflow.
REQ-028 Push when full with no pop: token dropped, overflow set sticky until next accepted start.
REQ-029 start outside IDLE ignored; start in DONE cycle ignored.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-031 reset asserted: state IDLE, enc_rst=1, rom_rd=0, rom_addr=0, FIFO empty, tok_valid=0, tok_* =0, busy=0, done=0, overflow=0.
REQ-032 reset mid-frame: aborts immediately; queued tokens discarded; no done pulse.
REQ-033 Accepted start clears overflow and FIFO.

Configuration
REQ-034 Macro LZ77_CTRL_STATS_EN defined: extra outputs stat_tokens[13:0] (tokens pushed) and stat_literals[13:0] (pushed tokens with match_len==0), cleared on reset and accepted start, saturating at 16383.
REQ-035 Macro undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-036 ROM all 8'h00, tok_ready=1: start -> first token offset=0,len=0,char=0x00; last token char=0x24, tok_last=1; done one cycle after FIFO empties.
REQ-037 ROM address k holds k[3:0] byte: check rom_addr 0..8191 contiguous, enc_chardata byte k on encoder edge k after enc_rst release.
REQ-038 tok_ready=0 throughout encode: after FIFO_DEPTH tokens overflow=1, remaining tokens dropped; next start clears overflow.
REQ-039 Full FIFO with simultaneous push and pop: count stays FIFO_DEPTH, overflow stays 0, order preserved.
REQ-040 reset pulsed mid-LOAD at rom_addr=100: all outputs to reset values next cycle; new start reloads from address 0.
REQ-041 With LZ77_CTRL_STATS_EN, all-zero ROM: stat_tokens equals pushed token count; stat_literals=1.
